// File: rtl/dlatch_mon_pkg.sv
// Shared types and default constants for the latch response monitor.
package dlatch_mon_pkg;

  localparam int CNT_W_DEF    = 12;
  localparam int TIMEOUT_DEF  = 64;
  localparam int COMP_TOL_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    PENDING = 2'd2
  } mon_state_t;

  // Q matches the target and Q_bar is its complement in the same sample.
  function automatic logic is_settled(input logic q, input logic qb, input logic exp_v);
    return (q == exp_v) && (qb == ~exp_v);
  endfunction

endpackage

// File: rtl/dlatch_response_monitor_sync2.sv
// Two-flop synchronizer bank for the asynchronous latch signals.
module dlatch_response_monitor_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= {W{1'b0}};
      s2_q <= {W{1'b0}};
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/dlatch_response_monitor.sv
// Measures D/enable-to-Q settle delay of a clocked D latch and flags
// complement, hold and timeout faults, all on synchronized samples.
module dlatch_response_monitor
  import dlatch_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int COMP_TOL = COMP_TOL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lat_d,
  input  logic             lat_en,
  input  logic             lat_q,
  input  logic             lat_qb,
  input  logic             clear,
  output logic             delay_valid,
  output logic [CNT_W-1:0] delay_cycles,
  output logic [CNT_W-1:0] max_delay,
  output logic [CNT_W-1:0] event_cnt,
  output logic             timeout_err,
  output logic             comp_err,
  output logic             hold_err,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] COMP_TOL_C = CNT_W'(COMP_TOL);

  logic [3:0] sync_s;
  logic       d_s, en_s, q_s, qb_s;

  dlatch_response_monitor_sync2 #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({lat_d, lat_en, lat_q, lat_qb}),
    .dout  (sync_s)
  );

  assign {d_s, en_s, q_s, qb_s} = sync_s;

  mon_state_t       state_d, state_q;
  logic             exp_val_d, exp_val_q;
  logic             q_prev_d, q_prev_q;
  logic [CNT_W-1:0] dcnt_d, dcnt_q;
  logic [CNT_W-1:0] ccnt_d, ccnt_q;
  logic             delay_valid_d, delay_valid_q;
  logic [CNT_W-1:0] delay_cycles_d, delay_cycles_q;
  logic [CNT_W-1:0] max_delay_d, max_delay_q;
  logic [CNT_W-1:0] event_cnt_d, event_cnt_q;
  logic             timeout_err_d, timeout_err_q;
  logic             comp_err_d, comp_err_q;
  logic             hold_err_d, hold_err_q;

  logic             tgt_chg_s, settle_s, pulse_s, to_set_s, hold_set_s, comp_set_s;
  logic [CNT_W-1:0] dcnt_inc_s, max_base_s, evt_base_s;

  always_comb begin
    exp_val_d  = en_s ? d_s : exp_val_q;
    tgt_chg_s  = (exp_val_d != exp_val_q);
    settle_s   = is_settled(q_s, qb_s, exp_val_q);
    q_prev_d   = q_s;
    // Elapsed cycles include the cycle in which the change was observed.
    dcnt_inc_s = dcnt_q + ONE_C;

    state_d    = state_q;
    dcnt_d     = dcnt_q;
    pulse_s    = 1'b0;
    to_set_s   = 1'b0;
    hold_set_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d = PENDING;
          dcnt_d  = ZERO_C;
        end else begin
          dcnt_d  = ZERO_C;
        end
      end
      TRACK: begin
        if (tgt_chg_s) begin
          state_d = PENDING;
          dcnt_d  = ZERO_C;
        end else if (!en_s && (q_s != q_prev_q)) begin
          hold_set_s = 1'b1;
        end else begin
          dcnt_d = dcnt_q;
        end
      end
      PENDING: begin
        if (tgt_chg_s) begin
          dcnt_d = ZERO_C;
        end else if (settle_s) begin
          pulse_s = 1'b1;
          state_d = TRACK;
          dcnt_d  = dcnt_inc_s;
        end else if (dcnt_inc_s == TIMEOUT_C) begin
          to_set_s = 1'b1;
          state_d  = IDLE;
          dcnt_d   = ZERO_C;
        end else begin
          dcnt_d = dcnt_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = ZERO_C;
      end
    endcase
  end

  // Complement watchdog: run length of Q==Q_bar, saturating at the tolerance.
  always_comb begin
    ccnt_d     = ZERO_C;
    comp_set_s = 1'b0;
    if ((state_q != IDLE) && (q_s == qb_s)) begin
      ccnt_d     = (ccnt_q >= COMP_TOL_C) ? COMP_TOL_C : (ccnt_q + ONE_C);
      comp_set_s = (ccnt_d >= COMP_TOL_C);
    end else begin
      ccnt_d = ZERO_C;
    end
  end

  always_comb begin
    max_base_s     = clear ? ZERO_C : max_delay_q;
    evt_base_s     = clear ? ZERO_C : event_cnt_q;
    delay_valid_d  = pulse_s;
    delay_cycles_d = pulse_s ? dcnt_inc_s : delay_cycles_q;
    max_delay_d    = max_base_s;
    event_cnt_d    = evt_base_s;
    if (pulse_s) begin
      max_delay_d = (dcnt_inc_s > max_base_s) ? dcnt_inc_s : max_base_s;
      event_cnt_d = (evt_base_s == MAX_C) ? MAX_C : (evt_base_s + ONE_C);
    end else begin
      max_delay_d = max_base_s;
    end
    // A flag being set in the same cycle as clear stays set.
    timeout_err_d = to_set_s   | (timeout_err_q & ~clear);
    comp_err_d    = comp_set_s | (comp_err_q    & ~clear);
    hold_err_d    = hold_set_s | (hold_err_q    & ~clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      exp_val_q      <= 1'b0;
      q_prev_q       <= 1'b0;
      dcnt_q         <= ZERO_C;
      ccnt_q         <= ZERO_C;
      delay_valid_q  <= 1'b0;
      delay_cycles_q <= ZERO_C;
      max_delay_q    <= ZERO_C;
      event_cnt_q    <= ZERO_C;
      timeout_err_q  <= 1'b0;
      comp_err_q     <= 1'b0;
      hold_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      exp_val_q      <= exp_val_d;
      q_prev_q       <= q_prev_d;
      dcnt_q         <= dcnt_d;
      ccnt_q         <= ccnt_d;
      delay_valid_q  <= delay_valid_d;
      delay_cycles_q <= delay_cycles_d;
      max_delay_q    <= max_delay_d;
      event_cnt_q    <= event_cnt_d;
      timeout_err_q  <= timeout_err_d;
      comp_err_q     <= comp_err_d;
      hold_err_q     <= hold_err_d;
    end
  end

  assign delay_valid  = delay_valid_q;
  assign delay_cycles = delay_cycles_q;
  assign max_delay    = max_delay_q;
  assign event_cnt    = event_cnt_q;
  assign timeout_err  = timeout_err_q;
  assign comp_err     = comp_err_q;
  assign hold_err     = hold_err_q;
  assign state_o      = state_q;

endmodule

// File: doc/dlatch_response_monitor.md
Name: dlatch_response_monitor

Overview:
- Downstream consumer of the clocked D latch with delay.
- Samples the latch stimulus (D, clk-as-enable) and its outputs (Q, Q_bar) on a fast system clock.
- Measures the enable/D-to-Q propagation delay in system-clock cycles and flags functional faults (complement violation, hold violation, settle timeout).
- Used in place of waveform inspection for pass/fail on latch-with-delay experiments.

Parameters:
- CNT_W, 12, width of delay counters, max_delay and event counter.
- TIMEOUT, 64, cycles allowed for Q to reach its expected value before timeout_err.
- COMP_TOL, 8, consecutive cycles Q==Q_bar may persist (transient) before comp_err.

Ports:
- clk  input  1  system sampling clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lat_d  input  1  latch D input (asynchronous to clk).
- lat_en  input  1  latch clock/enable (asynchronous to clk).
- lat_q  input  1  latch Q (asynchronous to clk).
- lat_qb  input  1  latch Q_bar (asynchronous to clk).
- clear  input  1  synchronous; clears sticky flags, max_delay and event_cnt.
- delay_valid  output  1  one-cycle pulse when a settle completes.
- delay_cycles  output  CNT_W  measured delay; valid with delay_valid, holds between pulses.
- max_delay  output  CNT_W  largest delay_cycles since reset/clear.
- event_cnt  output  CNT_W  number of completed settles; saturates at all-ones.
- timeout_err  output  1  sticky.
- comp_err  output  1  sticky.
- hold_err  output  1  sticky.
- state_o  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, synchronizer flops 0, exp_q 0.
- Input capture: all four latch signals pass through 2-flop synchronizers, so d_s, en_s, q_s and qb_s lag their pins by 2 cycles. All measurement is relative to the synchronized signals.
- Expected value: exp_q <= d_s whenever en_s=1; exp_q holds while en_s=0. A target change occurs when the next exp_q differs from the current exp_q.
- FSM IDLE (encoding 0):
  - Wait for the first cycle with en_s=1, then load exp_q.
  - Go to PENDING with dcnt=0.
  - No errors are checked in IDLE.
- FSM TRACK (encoding 1), Q settled:
  - On a target change, go to PENDING with dcnt=0.
  - If q_s changes while en_s=0, assert hold_err and stay in TRACK.
- FSM PENDING (encoding 2), waiting for settle:
  - dcnt increments each cycle.
  - Settle condition: q_s==exp_q and qb_s==~exp_q in the same cycle.
  - On settle, delay_valid=1 for one cycle, delay_cycles=dcnt, max_delay updated if larger, event_cnt+1, next state TRACK.
  - A target change while in PENDING restarts dcnt at 0; the delay is measured from the latest change only.
  - When dcnt reaches TIMEOUT: assert timeout_err, go to IDLE (re-acquire).
- Encoding 3 is unused; it recovers to IDLE.
- Complement check (TRACK and PENDING): a counter runs while q_s==qb_s and resets otherwise. Reaching COMP_TOL sets comp_err. The counter saturates.
- Latency: delay_valid asserts on the cycle after the settle condition is seen on the synchronized signals.
- Simultaneous events:
  - Settle and target change in the same cycle: the target change wins (restart, no pulse).
  - clear and an error set in the same cycle: the error wins (flag reads 1).
  - clear and a settle in the same cycle: max_delay loads the new dcnt and event_cnt becomes 1.
- Saturation: dcnt never wraps because TIMEOUT < 2^CNT_W; event_cnt holds at 2^CNT_W-1.
- Reset mid-operation: immediate return to reset values; no pulse is emitted.

Decomposition:
- Package dlatch_mon_pkg:
  - typedef enum logic[1:0] {IDLE, TRACK, PENDING} mon_state_t.
  - Default constants for CNT_W, TIMEOUT and COMP_TOL.
- Sub-module sync2: parameterized-width 2-flop synchronizer with async active-low reset; instantiated once at width 4.

Test Plan:
- Reset then en=1, d=1, q/qb model rising 5 cycles after d (qb falling in the same cycle) -> delay_valid pulse with delay_cycles=5+sync offset (fixed, checked against the model), event_cnt=1, state TRACK.
- en=0, toggle d every 20 cycles, q held -> no delay_valid, no errors. Then force q to flip while en=0 -> hold_err=1 the following cycle.
- en=1, d toggles, model never responds -> timeout_err=1 exactly TIMEOUT cycles after the target change; state IDLE.
- q=qb=1 held 10 cycles in TRACK with COMP_TOL=8 -> comp_err=1 after the 8th cycle. A 3-cycle glitch -> comp_err stays 0.
- Target changes again 3 cycles into PENDING, q settles 4 cycles later -> one pulse with delay_cycles=4, event_cnt increments by 1.
- Pulse clear while timeout_err=1 -> flags, max_delay and event_cnt read 0. Assert rst_n low mid-PENDING -> all outputs 0 immediately, state IDLE.
